// File: rtl/row_product_feeder_pkg.sv
// Shared constants and slot-index type for the row product feeder and the row adder.
package row_product_feeder_pkg;

   localparam int N_TAPS = 28;
   localparam int PIX_W  = 10;
   localparam int WGT_W  = 19;
   localparam int PROD_W = 26;
   localparam int ROW_W  = N_TAPS * PROD_W;

   typedef logic [4:0] slot_idx_t;

   localparam slot_idx_t LAST_SLOT = 5'd27;

   // Successor slot index, wrapping from the last tap back to tap 0.
   function automatic slot_idx_t next_slot(input slot_idx_t idx);
      return (idx == LAST_SLOT) ? '0 : idx + 5'd1;
   endfunction

endpackage

// File: rtl/row_product_feeder_tap_multiplier.sv
// Registered signed-weight x unsigned-pixel multiply, truncated to the product slot width.
module tap_multiplier
   import row_product_feeder_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [PIX_W-1:0]  pix,
   input  logic [WGT_W-1:0]  wgt,
   output logic [PROD_W-1:0] prod
);

   logic [PROD_W-1:0] wgt_ext;
   logic [PROD_W-1:0] pix_ext;
   logic [PROD_W-1:0] prod_next;

   // Only the low PROD_W bits are kept, so extending both operands to PROD_W
   // and multiplying at that width gives the exact two's-complement truncation.
   assign wgt_ext   = {{(PROD_W-WGT_W){wgt[WGT_W-1]}}, wgt};
   assign pix_ext   = {{(PROD_W-PIX_W){1'b0}}, pix};
   assign prod_next = wgt_ext * pix_ext;

   always_ff @(posedge clk) begin
      if (rst) begin
         prod <= '0;
      end else begin
         prod <= prod_next;
      end
   end

endmodule

// File: rtl/row_product_feeder.sv
// Serial pixel/weight pairs in, one packed 28-product row out per completed row,
// double-buffered so the adder sees a stable row while the next one loads.
module row_product_feeder
   import row_product_feeder_pkg::*;
(
   input  logic             clk,
   input  logic             GlobalReset,
   input  logic             In_Valid,
   input  logic             In_First,
   input  logic [PIX_W-1:0] Pix_In,
   input  logic [WGT_W-1:0] Wgt_In,
   output logic [ROW_W-1:0] Result_28,
   output logic             Out_Valid,
   output logic             Busy,
   output logic [7:0]       Row_Count
);

   slot_idx_t         tap_cnt;
   slot_idx_t         accept_idx;
   slot_idx_t         s1_idx;
   slot_idx_t         s2_idx;
   logic              s1_valid;
   logic              s2_valid;
   logic [PIX_W-1:0]  s1_pix;
   logic [WGT_W-1:0]  s1_wgt;
   logic [PROD_W-1:0] prod;
   logic [PROD_W-1:0] work [N_TAPS];
   logic [ROW_W-1:0]  out_buf;
   logic [ROW_W-1:0]  done_row;

   // In_First restarts the row regardless of where the counter is.
   assign accept_idx = In_First ? '0 : tap_cnt;

   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         tap_cnt  <= '0;
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         s1_pix   <= '0;
         s1_wgt   <= '0;
      end else begin
         s1_valid <= In_Valid;
         if (In_Valid) begin
            s1_idx  <= accept_idx;
            s1_pix  <= Pix_In;
            s1_wgt  <= Wgt_In;
            tap_cnt <= next_slot(accept_idx);
         end
      end
   end

   tap_multiplier u_tap_multiplier (
      .clk  (clk),
      .rst  (GlobalReset),
      .pix  (s1_pix),
      .wgt  (s1_wgt),
      .prod (prod)
   );

   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         s2_valid <= 1'b0;
         s2_idx   <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_idx   <= s1_idx;
      end
   end

   // Completed row: working slots 0..26 plus the product landing in slot 27 this cycle.
   always_comb begin
      done_row = '0;
      for (int k = 0; k < N_TAPS; k++) begin
         done_row[(N_TAPS-1-k)*PROD_W +: PROD_W] = (k == N_TAPS-1) ? prod : work[k];
      end
   end

   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         for (int k = 0; k < N_TAPS; k++) begin
            work[k] <= '0;
         end
         out_buf   <= '0;
         Out_Valid <= 1'b0;
         Row_Count <= '0;
      end else begin
         Out_Valid <= 1'b0;
         if (s2_valid) begin
            work[s2_idx] <= prod;
            if (s2_idx == LAST_SLOT) begin
               out_buf   <= done_row;
               Out_Valid <= 1'b1;
               Row_Count <= Row_Count + 8'd1;
            end
         end
      end
   end

   assign Result_28 = out_buf;
   assign Busy      = (tap_cnt != '0) | s1_valid | s2_valid;

endmodule

// File: tb/tb_row_product_feeder.sv
// Bench for row_product_feeder: driver tasks feed pairs into a row model, a monitor
// checks every strobe against the expected queue and checks stability in between.
module tb_row_product_feeder;
   import row_product_feeder_pkg::*;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             GlobalReset;
   logic             In_Valid;
   logic             In_First;
   logic [PIX_W-1:0] Pix_In;
   logic [WGT_W-1:0] Wgt_In;
   logic [ROW_W-1:0] Result_28;
   logic             Out_Valid;
   logic             Busy;
   logic [7:0]       Row_Count;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   row_product_feeder dut (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .In_Valid    (In_Valid),
      .In_First    (In_First),
      .Pix_In      (Pix_In),
      .Wgt_In      (Wgt_In),
      .Result_28   (Result_28),
      .Out_Valid   (Out_Valid),
      .Busy        (Busy),
      .Row_Count   (Row_Count)
   );

   // ---------------- reference model ----------------
   logic [PROD_W-1:0] m_work [N_TAPS];
   int                m_cnt;
   logic [7:0]        m_rows;

   logic [ROW_W-1:0] exp_q[$];
   logic [7:0]       exp_cnt_q[$];
   int               exp_cyc_q[$];
   logic [ROW_W-1:0] exp_last;
   logic [7:0]       exp_rows_last;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   function automatic logic [PROD_W-1:0] ref_prod(input logic [PIX_W-1:0] p,
                                                  input logic [WGT_W-1:0] w);
      int          wi;
      int          pr;
      logic [31:0] pv;
      wi = int'($signed(w));
      pr = wi * int'(p);
      pv = pr;
      return pv[PROD_W-1:0];
   endfunction

   task automatic model_accept(input logic [PIX_W-1:0] p, input logic [WGT_W-1:0] w,
                               input bit first);
      int idx;
      logic [ROW_W-1:0] row;
      idx = first ? 0 : m_cnt;
      m_work[idx] = ref_prod(p, w);
      m_cnt = (idx + 1) % N_TAPS;
      if (idx == N_TAPS-1) begin
         for (int k = 0; k < N_TAPS; k++) row[(N_TAPS-1-k)*PROD_W +: PROD_W] = m_work[k];
         m_rows = m_rows + 8'd1;
         exp_q.push_back(row);
         exp_cnt_q.push_back(m_rows);
         exp_cyc_q.push_back(cyc + 2);
      end
   endtask

   task automatic model_clear();
      m_cnt = 0;
      m_rows = '0;
      for (int k = 0; k < N_TAPS; k++) m_work[k] = '0;
      exp_q.delete();
      exp_cnt_q.delete();
      exp_cyc_q.delete();
      exp_last = '0;
      exp_rows_last = '0;
   endtask

   // ---------------- comparison helpers ----------------
   task automatic cmp(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic flag_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input bit v, input bit f, input logic [PIX_W-1:0] p,
                        input logic [WGT_W-1:0] w);
      In_Valid = v;
      In_First = f;
      Pix_In   = p;
      Wgt_In   = w;
      @(posedge clk);
      #1;
      if (v) model_accept(p, w, f);
      In_Valid = 1'b0;
      In_First = 1'b0;
   endtask

   task automatic do_reset(input bit with_valid);
      GlobalReset = 1'b1;
      In_Valid    = with_valid;
      In_First    = 1'b0;
      Pix_In      = PIX_W'($urandom_range(1, 1023));
      Wgt_In      = WGT_W'($urandom_range(1, 1000));
      @(posedge clk);
      #1;
      GlobalReset = 1'b0;
      In_Valid    = 1'b0;
      model_clear();
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 80;
      while ((exp_q.size() != 0) && (budget > 0)) begin
         drive(1'b0, 1'b0, '0, '0);
         budget--;
      end
      if (exp_q.size() != 0) begin
         flag_fail({name, "_drain_timeout"});
         exp_q.delete();
         exp_cnt_q.delete();
         exp_cyc_q.delete();
      end
      repeat (3) drive(1'b0, 1'b0, '0, '0);
   endtask

   task automatic rand_row(input bit first_on_tap0, input int bubble_pct);
      for (int k = 0; k < N_TAPS; k++) begin
         while ($urandom_range(0, 99) < bubble_pct) drive(1'b0, 1'b0, '0, '0);
         drive(1'b1, (k == 0) && first_on_tap0, PIX_W'($urandom), WGT_W'($urandom));
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         if ((exp_cyc_q.size() != 0) && (exp_cyc_q[0] < cyc)) begin
            flag_fail("missing_strobe");
            void'(exp_q.pop_front());
            void'(exp_cnt_q.pop_front());
            void'(exp_cyc_q.pop_front());
         end
         if (Out_Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               flag_fail("unexpected_strobe");
            end else begin
               exp_last      = exp_q.pop_front();
               exp_rows_last = exp_cnt_q.pop_front();
               cmp("strobe_row", Result_28, exp_last);
               cmp("strobe_row_count", ROW_W'(Row_Count), ROW_W'(exp_rows_last));
               cmp("strobe_cycle", ROW_W'(cyc), ROW_W'(exp_cyc_q.pop_front()));
            end
         end else begin
            cmp("hold_row", Result_28, exp_last);
            cmp("hold_row_count", ROW_W'(Row_Count), ROW_W'(exp_rows_last));
            cmp("out_valid_low", ROW_W'(Out_Valid), '0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      GlobalReset = 1'b1;
      In_Valid    = 1'b0;
      In_First    = 1'b0;
      Pix_In      = '0;
      Wgt_In      = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b0);
      chk_en = 1'b1;

      // Reset then idle
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cmp("idle_busy", ROW_W'(Busy), '0);
         cmp("idle_result", Result_28, '0);
      end
      #1;

      // Single tap 0 product, everything else zero
      for (int k = 0; k < N_TAPS; k++)
         drive(1'b1, k == 0, (k == 0) ? 10'h0DE : 10'h000, (k == 0) ? 19'h7FFFD : 19'h00000);
      drain("t_tap0");
      cmp("t_tap0_slot0", ROW_W'(Result_28[727:702]), ROW_W'(26'h3FFFD66));
      cmp("t_tap0_rest", ROW_W'(Result_28[701:0]), '0);
      cmp("t_tap0_count", ROW_W'(Row_Count), ROW_W'(8'd1));
      cmp("t_tap0_busy", ROW_W'(Busy), '0);

      // Tap 7 and most-negative weight at tap 27
      for (int k = 0; k < N_TAPS; k++) begin
         if (k == 7)       drive(1'b1, 1'b0, 10'h0FE, 19'd42);
         else if (k == 27) drive(1'b1, 1'b0, 10'h2AA, 19'h40000);
         else              drive(1'b1, k == 0, 10'h000, 19'h00000);
      end
      drain("t_neg");
      cmp("t_neg_slot7", ROW_W'(Result_28[(N_TAPS-1-7)*PROD_W +: PROD_W]), ROW_W'(26'h00029AC));
      cmp("t_neg_slot27", ROW_W'(Result_28[25:0]), ROW_W'(26'h1580000));
      cmp("t_neg_count", ROW_W'(Row_Count), ROW_W'(8'd2));

      // Two back-to-back rows, value = index
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < N_TAPS; k++)
            drive(1'b1, k == 0, PIX_W'(k), 19'd1);
      drain("t_b2b");
      cmp("t_b2b_slot5", ROW_W'(Result_28[(N_TAPS-1-5)*PROD_W +: PROD_W]), ROW_W'(5));
      cmp("t_b2b_count", ROW_W'(Row_Count), ROW_W'(8'd4));

      // Bubbles and a row abandoned at tap 13 via In_First
      for (int k = 0; k < 13; k++) begin
         while ($urandom_range(0, 99) < 30) drive(1'b0, 1'b0, '0, '0);
         drive(1'b1, k == 0, PIX_W'($urandom), WGT_W'($urandom));
      end
      @(negedge clk);
      cmp("t_abandon_busy", ROW_W'(Busy), ROW_W'(1));
      #1;
      rand_row(1'b1, 30);
      drain("t_abandon");
      cmp("t_abandon_count", ROW_W'(Row_Count), ROW_W'(8'd5));
      for (int r = 0; r < 4; r++) rand_row(r[0], 20);
      drain("t_random");

      // Reset mid-row at tap 20, with In_Valid high on the reset edge
      for (int k = 0; k < 20; k++) drive(1'b1, k == 0, PIX_W'($urandom), WGT_W'($urandom));
      do_reset(1'b1);
      @(negedge clk);
      cmp("t_rst_busy", ROW_W'(Busy), '0);
      cmp("t_rst_valid", ROW_W'(Out_Valid), '0);
      cmp("t_rst_count", ROW_W'(Row_Count), '0);
      cmp("t_rst_result", Result_28, '0);
      #1;
      rand_row(1'b0, 10);
      drain("t_after_rst");
      cmp("t_after_rst_count", ROW_W'(Row_Count), ROW_W'(8'd1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/row_product_feeder.md
# row_product_feeder

Front-end feeding the 5-stage row adder. Accepts a serial stream of 28 pixel/weight pairs for one 28-tap neuron row and multiplies each pair (signed weight × unsigned pixel). It assembles the 28 truncated 26-bit products into the packed 728-bit product bus the adder consumes. A double-buffered output holds each completed row stable and strobes a one-cycle valid.

## Interface
- N_TAPS, 28, products per row
- PIX_W, 10, unsigned pixel width
- WGT_W, 19, two's-complement weight width
- PROD_W, 26, product slot width (matches adder input and Beta width)

- clk  in  1  rising-edge clock
- GlobalReset  in  1  synchronous, active-high reset
- In_Valid  in  1  pair on Pix_In/Wgt_In is accepted this cycle
- In_First  in  1  qualifies In_Valid; marks the pair as tap 0 of a new row
- Pix_In  in  PIX_W  pixel, unsigned
- Wgt_In  in  WGT_W  weight, signed
- Result_28  out  N_TAPS*PROD_W  packed products; tap 0 in [727:702], tap 27 in [25:0]
- Out_Valid  out  1  one-cycle strobe: Result_28 holds a newly completed row
- Busy  out  1  partial row in progress (tap counter ≠ 0 or pipeline occupied)
- Row_Count  out  8  completed rows since reset, wraps 255→0

## Operation
- Reset: all outputs, tap counter, pipeline valid, and both buffers cleared to 0.
- Stage 1 (register): on an accepted pair, register Pix_In, Wgt_In, and the slot index. The index is 0 if In_First, else the tap counter. Set the tap counter to index+1, wrapping 27→0.
- Stage 2 (multiply/write): product = $signed(Wgt) × $signed({1'b0,Pix}). Keep the low PROD_W bits of the 29-bit result (two's-complement truncation; no saturation). Write the product into working-buffer slot [index].
- When slot 27 is written, the same edge copies the whole working row, including this product, into the output buffer. Out_Valid = 1 for that cycle and Row_Count increments.
- The output buffer changes only on row completion. Result_28 holds the previous row while the next row loads.
- In_First while the counter ≠ 0 discards the partial row: the counter restarts at 1 and stale working slots are overwritten as the new row arrives. There is no Out_Valid for the abandoned row.
- In_Valid low inserts bubbles. The counter holds, and a row may span any number of cycles.
- Working-buffer slots are not cleared between rows. Every completed row has all 28 slots freshly written by construction.

## Timing
- Throughput: one pair per cycle, no backpressure. A full row completes every 28 accepted pairs.
- Latency: last pair (index 27) sampled at edge E. Result_28 updates and Out_Valid is high after edge E+2, for exactly one cycle.
- Back-to-back rows: Out_Valid pulses once every 28 cycles with continuous In_Valid. Each Result_28 value is stable for 28 cycles.
- GlobalReset mid-row: the next edge clears everything and any in-flight products are dropped. The first pair after reset deasserts needs In_First or counter = 0 (equivalent).
- GlobalReset wins over In_Valid on the same edge.
- Busy = (tap counter ≠ 0) | stage-1 valid | stage-2 valid.

## Structure
- The shared package holds the N_TAPS, PIX_W, WGT_W, and PROD_W constants and a slot-index typedef (5-bit). The 5-stage adder reuses the same package.
- One sub-module: tap_multiplier (registered signed × unsigned multiply with truncation to PROD_W), a single instance time-shared across taps.

## Test plan
- Reset then idle: Result_28 = 0, Out_Valid = 0, Busy = 0, Row_Count = 0 for 10 cycles.
- Stream pixel 0x0DE with weight 19'h7FFFD (−3) at tap 0 and zeros elsewhere. Expect slot [727:702] = 26'h3FFFD66 (−666) with all other slots 0, Out_Valid after E+2, Row_Count = 1.
- Stream pixel 0x0FE with weight 42 at tap 7, plus pixel 0x2AA (max-ish) with weight 19'h40000 (most negative) at tap 27. Expect 26'h00029AC in slot 7 and the low 26 bits of −262144×682 in [25:0].
- Two continuous rows with the tap value equal to its index: the first strobe has slot k = k×1. The row-1 Result_28 stays stable for the 28 cycles while row 2 loads. The second strobe comes exactly 28 cycles later.
- Random In_Valid bubbles plus In_First at tap 13 of a row. The partial row produces no strobe, and the next completed row matches a reference model.
- GlobalReset asserted at tap 20: all outputs are 0 next cycle. A fresh row completes normally with Row_Count = 1.
